// File: rtl/serial_uart_bridge_if.sv
// Serial MMIO byte channel between the processor's serial port and the UART bridge.
// The processor drives tx_data_in/tx_wren_in/rx_rden_in; the bridge drives the rest.
interface serial_uart_bridge_if;
    logic [7:0] tx_data_in;
    logic       tx_wren_in;
    logic       tx_ready_out;
    logic [7:0] rx_data_out;
    logic       rx_valid_out;
    logic       rx_rden_in;

    modport master (
        output tx_data_in, tx_wren_in, rx_rden_in,
        input  tx_ready_out, rx_data_out, rx_valid_out
    );

    modport slave (
        input  tx_data_in, tx_wren_in, rx_rden_in,
        output tx_ready_out, rx_data_out, rx_valid_out
    );
endinterface

// File: rtl/serial_uart_bridge.sv
// Board-side UART endpoint of the serial MMIO channel: TX FIFO + 8N1 shifter,
// 8N1 receiver + RX FIFO, with sticky overflow / overrun / framing-error flags.
module serial_uart_bridge_fifo #(
    parameter int AW = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_empty
);
    localparam int            DEPTH   = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    // Full/empty come from the pre-edge count, so a push while full is lost
    // even when a pop happens in the same cycle.
    assign o_full  = (r_cnt == CNT_MAX);
    assign o_empty = (r_cnt == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = o_empty ? 8'h00 : r_mem[r_rd];

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PTR_ONE;
            if (w_pop)  r_rd <= r_rd + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// TX/RX state | meaning
//   IDLE      | line idle; TX waits for a queued byte, RX waits for a falling edge
//   START     | start bit (TX drives 0, RX waits half a bit and re-checks)
//   DATA      | 8 data bits, LSB first, one per CLKS_PER_BIT cycles
//   STOP      | stop bit (RX stays here after a low stop until the line is high)
module serial_uart_bridge #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int FIFO_ADDR_BITS = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    serial_uart_bridge_if.slave  bus,
    input  logic                 uart_rxd_in,
    output logic                 uart_txd_out,
    output logic                 tx_busy_out,
    output logic                 tx_overflow_out,
    output logic                 rx_overrun_out,
    output logic                 rx_frame_err_out,
    input  logic                 err_clr_in
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

    logic [7:0] w_txf_head;
    logic       w_txf_full;
    logic       w_txf_empty;
    logic [7:0] w_rxf_head;
    logic       w_rxf_full;
    logic       w_rxf_empty;

    uart_state_t r_tx_state;
    uart_state_t w_tx_next;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_idx;
    logic [7:0]    r_tx_shift;
    logic          r_txd;
    logic          w_tx_pop;
    logic          w_tx_busy;
    logic          w_tx_line;

    uart_state_t r_rx_state;
    uart_state_t w_rx_next;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_idx;
    logic [7:0]    r_rx_shift;
    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          r_rx_prev;
    logic          r_rx_ferr_wait;
    logic          w_rx_fall;
    logic          w_rx_sample;
    logic          w_rx_push_req;
    logic          w_rx_ferr;

    logic r_tx_ovf;
    logic r_rx_ovr;
    logic r_rx_ferr;

    serial_uart_bridge_fifo #(.AW(FIFO_ADDR_BITS)) u_tx_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (bus.tx_wren_in),
        .i_data  (bus.tx_data_in),
        .i_pop   (w_tx_pop),
        .o_head  (w_txf_head),
        .o_full  (w_txf_full),
        .o_empty (w_txf_empty)
    );

    serial_uart_bridge_fifo #(.AW(FIFO_ADDR_BITS)) u_rx_fifo (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_push  (w_rx_push_req),
        .i_data  (r_rx_shift),
        .i_pop   (bus.rx_rden_in),
        .o_head  (w_rxf_head),
        .o_full  (w_rxf_full),
        .o_empty (w_rxf_empty)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_tx_state <= ST_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            ST_IDLE:  if (!w_txf_empty) w_tx_next = ST_START;
            ST_START: if (r_tx_cnt == '0) w_tx_next = ST_DATA;
            ST_DATA:  if (r_tx_cnt == '0 && r_tx_idx == 3'd7) w_tx_next = ST_STOP;
            ST_STOP:  if (r_tx_cnt == '0) w_tx_next = ST_IDLE;
            default:  w_tx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_tx_pop  = (r_tx_state == ST_IDLE) && !w_txf_empty;
        w_tx_busy = (r_tx_state != ST_IDLE);
        case (r_tx_state)
            ST_START: w_tx_line = 1'b0;
            ST_DATA:  w_tx_line = r_tx_shift[r_tx_idx];
            default:  w_tx_line = 1'b1;
        endcase
    end

    // The line level is registered, so it lags the state by one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_txd <= w_tx_line;
            if (w_tx_next == ST_IDLE)
                r_tx_cnt <= '0;
            else if (w_tx_next != r_tx_state || (r_tx_state == ST_DATA && r_tx_cnt == '0))
                r_tx_cnt <= CNT_BIT;
            else if (r_tx_cnt != '0)
                r_tx_cnt <= r_tx_cnt - CNT_ONE;
            if (w_tx_pop) begin
                r_tx_shift <= w_txf_head;
                r_tx_idx   <= '0;
            end else if (r_tx_state == ST_DATA && r_tx_cnt == '0) begin
                r_tx_idx <= r_tx_idx + 3'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= uart_rxd_in;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev && !r_rx_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_rx_state <= ST_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            ST_IDLE:  if (w_rx_fall) w_rx_next = ST_START;
            ST_START: if (r_rx_cnt == '0) w_rx_next = r_rx_sync ? ST_IDLE : ST_DATA;
            ST_DATA:  if (r_rx_cnt == '0 && r_rx_idx == 3'd7) w_rx_next = ST_STOP;
            ST_STOP: begin
                if (r_rx_ferr_wait) begin
                    if (r_rx_sync) w_rx_next = ST_IDLE;
                end else if (r_rx_cnt == '0 && r_rx_sync) begin
                    w_rx_next = ST_IDLE;
                end
            end
            default:  w_rx_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rx_sample   = (r_rx_state == ST_DATA) && (r_rx_cnt == '0);
        w_rx_push_req = (r_rx_state == ST_STOP) && !r_rx_ferr_wait && (r_rx_cnt == '0) && r_rx_sync;
        w_rx_ferr     = (r_rx_state == ST_STOP) && !r_rx_ferr_wait && (r_rx_cnt == '0) && !r_rx_sync;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_cnt       <= '0;
            r_rx_idx       <= '0;
            r_rx_shift     <= '0;
            r_rx_ferr_wait <= 1'b0;
        end else begin
            if (w_rx_next != r_rx_state || w_rx_sample) begin
                case (w_rx_next)
                    ST_START: r_rx_cnt <= CNT_HALF;
                    ST_IDLE:  r_rx_cnt <= '0;
                    default:  r_rx_cnt <= CNT_BIT;
                endcase
            end else if (r_rx_cnt != '0) begin
                r_rx_cnt <= r_rx_cnt - CNT_ONE;
            end
            if (r_rx_state == ST_START)
                r_rx_idx <= '0;
            else if (w_rx_sample)
                r_rx_idx <= r_rx_idx + 3'd1;
            if (w_rx_sample)
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            if (w_rx_ferr)
                r_rx_ferr_wait <= 1'b1;
            else if (w_rx_next == ST_IDLE)
                r_rx_ferr_wait <= 1'b0;
        end
    end

    // A new error in the same cycle as err_clr_in keeps the flag set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx_ovf  <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_rx_ferr <= 1'b0;
        end else begin
            r_tx_ovf  <= (bus.tx_wren_in && w_txf_full) ? 1'b1 : (err_clr_in ? 1'b0 : r_tx_ovf);
            r_rx_ovr  <= (w_rx_push_req && w_rxf_full)  ? 1'b1 : (err_clr_in ? 1'b0 : r_rx_ovr);
            r_rx_ferr <= w_rx_ferr                      ? 1'b1 : (err_clr_in ? 1'b0 : r_rx_ferr);
        end
    end

    assign uart_txd_out     = r_txd;
    assign tx_busy_out      = w_tx_busy;
    assign tx_overflow_out  = r_tx_ovf;
    assign rx_overrun_out   = r_rx_ovr;
    assign rx_frame_err_out = r_rx_ferr;
    assign bus.tx_ready_out = !w_txf_full;
    assign bus.rx_valid_out = !w_rxf_empty;
    assign bus.rx_data_out  = w_rxf_head;
endmodule

// File: doc/serial_uart_bridge.md
Name: serial_uart_bridge

Overview:
- Board-side endpoint of the processor's serial MMIO byte channel.
- TX path: accepts bytes that the memory-mapped serial port writes out, buffers them, and shifts them onto a UART line as 8N1 frames.
- RX path: deserialises incoming 8N1 frames, buffers the bytes, and presents them as valid bytes for the serial port to read.
- Sits at top level between the processor's serial pins and the board UART pins.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit; must be >= 4. The default gives 115200 baud at 50 MHz.
- FIFO_ADDR_BITS, 2, log2 depth of each FIFO; default depth is 4.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_data_in  in  8  byte from the processor (connects to serial_out).
- tx_wren_in  in  1  one-cycle write strobe for tx_data_in.
- tx_ready_out  out  1  TX FIFO not full (connects to serial_ready_in).
- rx_data_out  out  8  head byte of the RX FIFO (connects to serial_in).
- rx_valid_out  out  1  RX FIFO not empty (connects to serial_valid_in).
- rx_rden_in  in  1  one-cycle pop strobe (connects to serial_rden_out).
- uart_rxd_in  in  1  asynchronous serial input; idles high.
- uart_txd_out  out  1  serial output; idles high.
- tx_busy_out  out  1  a TX frame is in progress.
- tx_overflow_out  out  1  sticky: a write arrived while the TX FIFO was full.
- rx_overrun_out  out  1  sticky: a received byte was dropped because the RX FIFO was full.
- rx_frame_err_out  out  1  sticky: a stop bit was sampled low.
- err_clr_in  in  1  clears all sticky flags. If it coincides with a new error, the set wins.

Behaviour:
- Reset values (asserted asynchronously while reset = 0):
  - uart_txd_out = 1, tx_ready_out = 1, tx_busy_out = 0.
  - rx_valid_out = 0, rx_data_out = 0x00.
  - All sticky flags = 0.
  - Both FIFOs empty; both FSMs in IDLE; all counters at 0.
  - Reset mid-frame aborts the frame: the line returns high immediately and no partial byte is kept.
- FIFOs:
  - Synchronous, first-word-fall-through, depth 2^FIFO_ADDR_BITS, with read/write pointers plus a count.
  - Full and empty are evaluated on the pre-edge state.
  - A push while full is dropped and sets the overflow/overrun flag, even if a pop happens in the same cycle.
  - A pop while empty is ignored.
  - Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
  - tx_ready_out = !tx_full; rx_valid_out = !rx_empty.
  - rx_data_out shows the head entry, or 0x00 when empty.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE with FIFO non-empty: pop into the shift register and go to START. tx_busy_out = 1 in every state except IDLE.
  - START: drive 0 for CLKS_PER_BIT cycles.
  - DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit index.
  - STOP: drive 1 for CLKS_PER_BIT cycles, then return to IDLE. A byte already queued starts its START on the next cycle, so the gap between frames is at most 1 cycle.
  - Latency: a write sampled at edge N into an empty FIFO with the FSM in IDLE gives uart_txd_out = 0 from edge N+2.
- RX synchronisation: uart_rxd_in passes through a 2-flop synchroniser, and the falling-edge detector looks at the synchronised signal.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: on a synchronised falling edge, go to START.
  - START: wait CLKS_PER_BIT/2 cycles (floor). If the line is still 0, go to DATA; otherwise treat it as a glitch and return to IDLE with nothing pushed.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 samples.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: push the byte. rx_valid_out rises the cycle after the stop-bit sample.
    - If 0: drop the byte, set rx_frame_err_out, and wait for the line to go high before returning to IDLE.
- TX and RX run fully independently; simultaneous activity on both is legal.

Test Plan (CLKS_PER_BIT = 4, FIFO_ADDR_BITS = 2):
1. One-byte transmit:
   - Stimulus: write 0x55 at edge N, FSM idle.
   - Required: txd = 0 during edges N+2..N+5; data bits 1,0,1,0,1,0,1,0 for 4 cycles each; stop 1 for 4 cycles; tx_busy_out high for exactly 40 cycles; no sticky flags set.
2. TX overflow:
   - Stimulus: while frame 0x01 is in flight, write 0x02..0x06 on consecutive cycles.
   - Required: tx_ready_out falls after the 4th write; 0x06 is dropped; tx_overflow_out = 1; the line carries 0x01, 0x02, 0x03, 0x04, 0x05 in order; err_clr_in clears the flag.
3. One-byte receive:
   - Stimulus: drive an 0xA3 frame on rxd.
   - Required: rx_valid_out = 1 and rx_data_out = 0xA3 after the stop sample; rx_rden_in for 1 cycle gives rx_valid_out = 0 and rx_data_out = 0x00.
4. RX glitch and framing error:
   - Stimulus: a 1-cycle low pulse on rxd; then a frame 0x3C with its stop bit held low.
   - Required: the pulse produces no byte and no flag; the bad frame produces no byte and rx_frame_err_out = 1; a following valid 0x7E is received correctly.
5. RX overrun:
   - Stimulus: receive 0x11, 0x22, 0x33, 0x44, 0x55 with no reads.
   - Required: rx_overrun_out = 1; popping yields 0x11, 0x22, 0x33, 0x44, then rx_valid_out = 0.
6. Reset mid-frame:
   - Stimulus: assert reset in the middle of the DATA bits of a TX frame while the RX path is mid-frame.
   - Required: txd = 1 asynchronously; FIFOs empty; flags 0; after release, a write of 0xC3 transmits a clean frame, and a fresh RX frame 0x5A is received correctly.
